fetch_unit: RTL

Instruction fetch stage of the RV32 core: owns the program counter, issues word requests to instruction memory, buffers returned instructions in a small in-order queue, and presents them with their PC to the instruction decoder through a valid/ready handshake. Branch and jump redirects from downstream flush the queue, discard in-flight responses, and restart fetch at the target address.

---
 rtl/fetch_unit.sv | 99 +++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word requests to instruction memory,
// buffers in-order responses in a small queue and hands {inst, pc} to the decoder.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] LP_DEPTH = (CW+1)'(DEPTH);

    logic [31:0]   r_pc;
    logic [31:0]   r_q_inst [DEPTH];
    logic [31:0]   r_q_pc   [DEPTH];
    logic [31:0]   r_tag    [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_tag_rd;
    logic [PW-1:0] r_tag_wr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_out;
    logic [CW-1:0] r_drop;

    logic [CW:0]   w_inflight;
    logic [31:0]   w_tgt;
    logic          w_gnt;
    logic          w_rsp;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_out_nxt;

    // Buffered plus outstanding never exceeds DEPTH, so a response always has a slot.
    assign w_inflight = {1'b0, r_count} + {1'b0, r_out};
    assign imem_req   = rst_n & (w_inflight < LP_DEPTH);
    assign imem_addr  = r_pc;
    assign w_tgt      = redirect_pc & ~32'h0000_0003;

    assign w_gnt     = imem_req & imem_gnt;
    assign w_rsp     = imem_rvalid & (r_out != '0);
    assign w_push    = w_rsp & (r_drop == '0) & ~redirect_en;
    assign w_pop     = inst_valid & inst_ready;
    assign w_out_nxt = r_out + CW'(w_gnt) - CW'(w_rsp);

    assign inst_valid = (r_count != '0);
    assign inst       = inst_valid ? r_q_inst[r_rd_ptr] : '0;
    assign inst_pc    = inst_valid ? r_q_pc[r_rd_ptr]   : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= RESET_PC;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_tag_rd <= '0;
            r_tag_wr <= '0;
            r_count  <= '0;
            r_out    <= '0;
            r_drop   <= '0;
        end else begin
            r_out <= w_out_nxt;
            if (w_gnt) r_tag_wr <= r_tag_wr + PW'(1);
            if (w_rsp) r_tag_rd <= r_tag_rd + PW'(1);
            if (redirect_en) begin
                // Every request still owed by memory after this edge is wrong-path.
                r_pc     <= w_tgt;
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
                r_drop   <= w_out_nxt;
            end else begin
                if (w_gnt)  r_pc     <= r_pc + 32'd4;
                if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
                if (w_rsp && (r_drop != '0)) r_drop <= r_drop - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_gnt) r_tag[r_tag_wr] <= r_pc;
        if (w_push) begin
            r_q_inst[r_wr_ptr] <= imem_rdata;
            r_q_pc[r_wr_ptr]   <= r_tag[r_tag_rd];
        end
    end
endmodule
